// File: rtl/retire_stage.sv
// retire_stage: in-order commit stage of the out-of-order core.
//
// Each cycle the stage scans the oldest ROB head entries, retires the
// longest complete prefix (ending early on a halt or mispredicted branch),
// tells the ROB how many entries to pop, and registers the architectural
// map-table writes plus the freed T_old physical registers for next cycle.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high reset
//   rob_outputs    oldest-first ROB head entries
//   outputs_valid  number of valid head entries
//   num_retiring   entries popped from the ROB this cycle (combinational)
//   free_count     number of valid free_regs entries (registered)
//   free_regs      freed T_old registers, packed from index 0 (registered)
//   amt_we         arch map table write enables, one per entry slot (registered)
//   amt_arch       arch register index per write (registered)
//   amt_preg       T_new physical register per write (registered)
//   rollback       one-cycle flush pulse after a mispredicted branch retires
//   halted         sticky flag once a halt entry has retired
//   retired_count  running total of retired entries (wraps)

`ifndef N
`define N 4
`endif

`ifndef PHYS_REG_ID_BITS
`define PHYS_REG_ID_BITS 6
`endif

package retire_stage_pkg;
    typedef struct packed {
        logic                         complete;
        logic                         halt;
        logic                         mispredict;
        logic [4:0]                   Arch_reg;
        logic [`PHYS_REG_ID_BITS-1:0] T_new;
        logic [`PHYS_REG_ID_BITS-1:0] T_old;
    } ROB_EXIT_PACKET;
endpackage

module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int N        = `N,
    parameter int CNT_BITS = 32
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  ROB_EXIT_PACKET                       rob_outputs [N],
    input  logic [$clog2(N+1)-1:0]               outputs_valid,
    output logic [$clog2(N+1)-1:0]               num_retiring,
    output logic [$clog2(N+1)-1:0]               free_count,
    output logic [N-1:0][`PHYS_REG_ID_BITS-1:0]  free_regs,
    output logic [N-1:0]                         amt_we,
    output logic [N-1:0][4:0]                    amt_arch,
    output logic [N-1:0][`PHYS_REG_ID_BITS-1:0]  amt_preg,
    output logic                                 rollback,
    output logic                                 halted,
    output logic [CNT_BITS-1:0]                  retired_count
);

    localparam int W = $clog2(N+1);
    localparam int P = `PHYS_REG_ID_BITS;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;

    logic [W-1:0]             k_s;
    logic [N-1:0]             ret_mask_s;
    logic                     scan_stop_s;
    logic                     last_halt_s;
    logic                     last_mp_s;

    logic [N-1:0]             amt_we_nxt_s;
    logic [N-1:0][4:0]        amt_arch_nxt_s;
    logic [N-1:0][P-1:0]      amt_preg_nxt_s;
    logic [N-1:0][P-1:0]      free_nxt_s;
    logic [W-1:0]             free_idx_s;

    logic [W-1:0]             free_count_r;
    logic [N-1:0][P-1:0]      free_regs_r;
    logic [N-1:0]             amt_we_r;
    logic [N-1:0][4:0]        amt_arch_r;
    logic [N-1:0][P-1:0]      amt_preg_r;
    logic                     rollback_r;
    logic                     halted_r;
    logic [CNT_BITS-1:0]      retired_count_r;

    // Oldest-first scan: retire the complete prefix, closing it after a halt/mispredict.
    always_comb begin
        k_s         = {W{1'b0}};
        ret_mask_s  = {N{1'b0}};
        scan_stop_s = 1'b0;
        last_halt_s = 1'b0;
        last_mp_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!scan_stop_s && (W'(i) < outputs_valid) && rob_outputs[i].complete) begin
                ret_mask_s[i] = 1'b1;
                k_s           = k_s + W'(1'b1);
                last_halt_s   = rob_outputs[i].halt;
                last_mp_s     = rob_outputs[i].mispredict;
                scan_stop_s   = rob_outputs[i].halt | rob_outputs[i].mispredict;
            end else begin
                scan_stop_s   = 1'b1;
            end
        end
    end

    // Map-table writes stay in their entry slot; freed T_old registers are compacted.
    always_comb begin
        amt_we_nxt_s   = {N{1'b0}};
        amt_arch_nxt_s = '0;
        amt_preg_nxt_s = '0;
        free_nxt_s     = '0;
        free_idx_s     = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            // Arch_reg 0 is the hardwired zero register: no mapping to update or release.
            if (ret_mask_s[i] && (rob_outputs[i].Arch_reg != 5'd0)) begin
                amt_we_nxt_s[i]         = 1'b1;
                amt_arch_nxt_s[i]       = rob_outputs[i].Arch_reg;
                amt_preg_nxt_s[i]       = rob_outputs[i].T_new;
                free_nxt_s[free_idx_s]  = rob_outputs[i].T_old;
                free_idx_s              = free_idx_s + W'(1'b1);
            end else begin
                amt_we_nxt_s[i]         = 1'b0;
            end
        end
    end

    // Next-state logic; halt wins over mispredict on the same entry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (last_halt_s) begin
                    state_nxt_s = HALTED;
                end else if (last_mp_s) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH:   state_nxt_s = RUN;
            HALTED:  state_nxt_s = HALTED;
            default: state_nxt_s = RUN;
        endcase
    end

    // ROB pop count: only RUN retires, and nothing retires in a reset cycle.
    always_comb begin
        num_retiring = {W{1'b0}};
        if (reset) begin
            num_retiring = {W{1'b0}};
        end else if (state_r == RUN) begin
            num_retiring = k_s;
        end else begin
            num_retiring = {W{1'b0}};
        end
    end

    // State register and registered retirement results.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= RUN;
            free_count_r    <= {W{1'b0}};
            free_regs_r     <= '0;
            amt_we_r        <= {N{1'b0}};
            amt_arch_r      <= '0;
            amt_preg_r      <= '0;
            rollback_r      <= 1'b0;
            halted_r        <= 1'b0;
            retired_count_r <= {CNT_BITS{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            // Flags are registered copies of the state being entered.
            rollback_r <= (state_nxt_s == FLUSH);
            halted_r   <= (state_nxt_s == HALTED);
            if (state_r == RUN) begin
                free_count_r    <= free_idx_s;
                free_regs_r     <= free_nxt_s;
                amt_we_r        <= amt_we_nxt_s;
                amt_arch_r      <= amt_arch_nxt_s;
                amt_preg_r      <= amt_preg_nxt_s;
                retired_count_r <= retired_count_r + CNT_BITS'(k_s);
            end else begin
                free_count_r    <= {W{1'b0}};
                amt_we_r        <= {N{1'b0}};
                retired_count_r <= retired_count_r;
            end
        end
    end

    assign free_count    = free_count_r;
    assign free_regs     = free_regs_r;
    assign amt_we        = amt_we_r;
    assign amt_arch      = amt_arch_r;
    assign amt_preg      = amt_preg_r;
    assign rollback      = rollback_r;
    assign halted        = halted_r;
    assign retired_count = retired_count_r;

endmodule

// File: doc/retire_stage.md
RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 SHALL have parameter N, default `N, meaning the superscalar width (max entries retired per cycle).
REQ-002 SHALL have parameter CNT_BITS, default 32, meaning the width of the retired-instruction counter.
REQ-003 SHALL have port clock  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rob_outputs  input  ROB_EXIT_PACKET[N]  oldest-first ROB head entries; the block uses fields complete, halt, mispredict, Arch_reg, T_new, T_old.
REQ-006 SHALL have port outputs_valid  input  $clog2(N+1)  count of valid head entries.
REQ-007 SHALL have port num_retiring  output  $clog2(N+1)  entries the ROB clears this cycle; combinational.
REQ-008 SHALL have port free_count  output  $clog2(N+1)  count of valid free_regs; registered.
REQ-009 SHALL have port free_regs  output  [N][`PHYS_REG_ID_BITS]  T_old registers returned to the free list, packed from index 0; registered.
REQ-010 SHALL have port amt_we  output  N  arch map table write enables; registered.
REQ-011 SHALL have port amt_arch  output  [N][5]  arch register index per write; registered.
REQ-012 SHALL have port amt_preg  output  [N][`PHYS_REG_ID_BITS]  T_new per write; registered.
REQ-013 SHALL have port rollback  output  1  one-cycle flush pulse after a mispredicted branch retires.
REQ-014 SHALL have port halted  output  1  sticky flag set after a halt entry retires.
REQ-015 SHALL have port retired_count  output  CNT_BITS  running total of retired entries.

Function
REQ-016 SHALL compute k, the count of retireable entries: scan i = 0 .. outputs_valid-1 oldest-first, include entry i only if complete=1, and stop at the first incomplete entry.
REQ-017 SHALL include an entry with halt=1 or mispredict=1 in k and then stop the scan at that entry.
REQ-018 SHALL implement an FSM with states RUN, FLUSH and HALTED; reset state is RUN.
REQ-019 In RUN, SHALL drive num_retiring = k.
REQ-020 In RUN, SHALL go to HALTED if the last retired entry has halt=1.
REQ-021 In RUN, SHALL go to FLUSH if the last retired entry has mispredict=1; halt has priority if both are set.
REQ-022 In FLUSH, SHALL drive num_retiring = 0 and rollback = 1 for exactly one cycle, then return to RUN.
REQ-023 In HALTED, SHALL drive num_retiring = 0 with halted = 1 until reset; inputs are ignored.
REQ-024 On the clock edge where k entries retire, SHALL register the following for the next cycle:
  - amt_we[j]=1, amt_arch[j]=Arch_reg, amt_preg[j]=T_new for each retired entry with Arch_reg != 0;
  - its T_old into free_regs, packed without gaps, with free_count set to the packed count.
REQ-025 SHALL give retired entries with Arch_reg == 0 no map write and no freed register.
REQ-026 SHALL register free_count = 0 and amt_we = 0 in any cycle that retires nothing.
REQ-027 SHALL add k to retired_count each RUN cycle, wrapping modulo 2^CNT_BITS.
REQ-028 SHALL produce num_retiring = 0 when outputs_valid = 0.
REQ-029 SHALL treat entries at index >= outputs_valid as invalid regardless of their contents.
REQ-030 SHALL ensure num_retiring never exceeds outputs_valid.

Reset
REQ-031 While reset = 1: state = RUN, num_retiring = 0, free_count = 0, amt_we = 0, rollback = 0, halted = 0, retired_count = 0.
REQ-032 Reset asserted while in FLUSH or HALTED SHALL return the block to RUN on the next edge with all outputs cleared; no retirement occurs in the reset cycle.

Verification
REQ-033 outputs_valid=2, both complete, Arch_reg={3,5}, T_new={40,41}, T_old={10,11} -> num_retiring=2; next cycle amt_we=2'b11, free_regs={10,11}, free_count=2, retired_count=2.
REQ-034 outputs_valid=N, entry0 complete, entry1 incomplete, remaining complete -> num_retiring=1; retired_count advances by 1.
REQ-035 outputs_valid=2, entry0 complete with mispredict=1, entry1 complete -> num_retiring=1; next cycle rollback=1 and num_retiring=0; the following cycle is RUN again.
REQ-036 entry0 complete with halt=1 -> num_retiring=1, then halted=1 and num_retiring=0 held for 10 cycles despite complete inputs; reset -> halted=0.
REQ-037 entry0 complete with Arch_reg=0 -> num_retiring=1, amt_we=0, free_count=0 next cycle.
REQ-038 Random stimulus for 10k cycles -> num_retiring <= outputs_valid every cycle, and retired_count equals the sum of num_retiring.
